// File: rtl/vector_cache_pkg.sv
// Shared vector-cache types: write-response payload, width constants and the 4-way round-robin pick.
package vector_cache_pkg;

    localparam int unsigned TXNID_WIDTH        = 8;
    localparam int unsigned SIDEBAND_WIDTH     = 4;
    localparam int unsigned DB_ENTRY_IDX_WIDTH = 6;
    localparam int unsigned WR_RSP_LANE_NUM    = 4;
    localparam int unsigned WR_RSP_LANE_W      = 2;

    typedef struct packed {
        logic [TXNID_WIDTH-1:0]        txnid;
        logic [SIDEBAND_WIDTH-1:0]     sideband;
        logic [DB_ENTRY_IDX_WIDTH-1:0] db_entry_id;
    } wr_resp_pld_t;

    // First requesting lane at or after ptr, wrapping; returns ptr when nothing requests.
    function automatic logic [WR_RSP_LANE_W-1:0] rr_pick(input logic [WR_RSP_LANE_NUM-1:0] req,
                                                         input logic [WR_RSP_LANE_W-1:0]   ptr);
        logic [WR_RSP_LANE_W-1:0] idx;
        rr_pick = ptr;
        for (int k = WR_RSP_LANE_NUM - 1; k >= 0; k--) begin
            idx = ptr + WR_RSP_LANE_W'(k);
            if (req[idx]) rr_pick = idx;
        end
    endfunction

endpackage

// File: rtl/wr_rsp_lane_fifo.sv
// Per-lane write-response FIFO: registered storage, combinational head, registered ready (not full).
module wr_rsp_lane_fifo
    import vector_cache_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  wr_resp_pld_t push_data,
    input  logic         pop,
    output logic         rdy,
    output logic         empty_c,
    output wr_resp_pld_t head_c
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    wr_resp_pld_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        count_nxt = count + CNT_W'(push) - CNT_W'(pop);
    end

    // Ready is held low through reset and tracks the post-update occupancy afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rdy    <= 1'b0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count_nxt;
            rdy   <= (count_nxt != CNT_W'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign empty_c = (count == '0);
    assign head_c  = mem[rd_ptr];

`ifndef SYNTHESIS
    a_no_push_full:  assert property (@(posedge clk) disable iff (!rst_n) push |-> (count != CNT_W'(DEPTH)));
    a_no_pop_empty:  assert property (@(posedge clk) disable iff (!rst_n) pop |-> (count != '0));
`endif

endmodule

// File: rtl/write_resp_xbar.sv
// Write-completion return crossbar: 4 lane FIFOs -> W_REQ_NUM requesters, RR per requester, WDB dealloc.
// Optional per-requester handshake counters with `WR_RESP_PERF_CNT_EN.
module write_resp_xbar
    import vector_cache_pkg::*;
#(
    parameter int unsigned W_REQ_NUM  = 8,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic [3:0]                                    wr_rsp_in_vld,
    output logic [3:0]                                    wr_rsp_in_rdy,
    input  wr_resp_pld_t [3:0]                            wr_rsp_in_pld,
    output logic [W_REQ_NUM-1:0]                          wr_rsp_vld,
    input  logic [W_REQ_NUM-1:0]                          wr_rsp_rdy,
    output logic [W_REQ_NUM-1:0][TXNID_WIDTH-1:0]         wr_rsp_txnid,
    output logic [W_REQ_NUM-1:0][SIDEBAND_WIDTH-1:0]      wr_rsp_sideband,
    output logic [3:0]                                    dealloc_vld,
    output logic [3:0][DB_ENTRY_IDX_WIDTH-1:0]            dealloc_idx
`ifdef WR_RESP_PERF_CNT_EN
    ,
    output logic [W_REQ_NUM-1:0][31:0]                    wr_rsp_cnt
`endif
);

    localparam int unsigned DEST_W = $clog2(W_REQ_NUM);

    logic [3:0]                          lane_push;
    logic [3:0]                          lane_pop;
    logic [3:0]                          lane_empty;
    wr_resp_pld_t [3:0]                  head;
    logic [3:0][DEST_W-1:0]              dest;

    logic [W_REQ_NUM-1:0][3:0]           req;
    logic [W_REQ_NUM-1:0]                any_req;
    logic [W_REQ_NUM-1:0]                hs;
    logic [W_REQ_NUM-1:0][1:0]           grant;
    logic [W_REQ_NUM-1:0][1:0]           rr_ptr;
    logic [W_REQ_NUM-1:0]                lock_vld;
    logic [W_REQ_NUM-1:0][1:0]           lock_lane;

    assign lane_push = wr_rsp_in_vld & wr_rsp_in_rdy;

    for (genvar i = 0; i < 4; i++) begin : g_lane
        wr_rsp_lane_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .push      (lane_push[i]),
            .push_data (wr_rsp_in_pld[i]),
            .pop       (lane_pop[i]),
            .rdy       (wr_rsp_in_rdy[i]),
            .empty_c   (lane_empty[i]),
            .head_c    (head[i])
        );
        assign dest[i] = head[i].txnid[DEST_W-1:0];
    end

    // Per-requester arbitration; a stalled grant stays locked so the payload cannot change under vld.
    always_comb begin
        req             = '0;
        any_req         = '0;
        hs              = '0;
        grant           = '0;
        lane_pop        = '0;
        wr_rsp_vld      = '0;
        wr_rsp_txnid    = '0;
        wr_rsp_sideband = '0;
        for (int j = 0; j < W_REQ_NUM; j++) begin
            for (int i = 0; i < 4; i++) begin
                req[j][i] = !lane_empty[i] && (dest[i] == DEST_W'(j));
            end
            any_req[j] = |req[j];
            grant[j]   = lock_vld[j] ? lock_lane[j] : rr_pick(req[j], rr_ptr[j]);
            hs[j]      = any_req[j] && wr_rsp_rdy[j];
            wr_rsp_vld[j]      = any_req[j];
            wr_rsp_txnid[j]    = head[grant[j]].txnid;
            wr_rsp_sideband[j] = head[grant[j]].sideband;
            if (hs[j]) lane_pop[grant[j]] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr      <= '0;
            lock_vld    <= '0;
            lock_lane   <= '0;
            dealloc_vld <= '0;
            dealloc_idx <= '0;
        end else begin
            for (int j = 0; j < W_REQ_NUM; j++) begin
                if (hs[j]) rr_ptr[j] <= grant[j] + 2'd1;
                lock_vld[j]  <= any_req[j] && !wr_rsp_rdy[j];
                lock_lane[j] <= grant[j];
            end
            dealloc_vld <= lane_pop;
            for (int i = 0; i < 4; i++) begin
                if (lane_pop[i]) dealloc_idx[i] <= head[i].db_entry_id;
            end
        end
    end

`ifdef WR_RESP_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_rsp_cnt <= '0;
        end else begin
            for (int j = 0; j < W_REQ_NUM; j++) begin
                if (hs[j]) wr_rsp_cnt[j] <= wr_rsp_cnt[j] + 32'd1;
            end
        end
    end
`else
    // Counters and their port are absent in this build.
`endif

`ifndef SYNTHESIS
    // Tracks WDB entries sitting in any lane FIFO so a duplicate id is flagged at push time.
    logic [(1 << DB_ENTRY_IDX_WIDTH)-1:0] db_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_busy <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (lane_pop[i])  db_busy[head[i].db_entry_id] <= 1'b0;
                if (lane_push[i]) db_busy[wr_rsp_in_pld[i].db_entry_id] <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_chk
        a_db_unique: assert property (@(posedge clk) disable iff (!rst_n)
            lane_push[i] |-> !db_busy[wr_rsp_in_pld[i].db_entry_id]);
    end

    a_req_pow2: assert property (@(posedge clk)
        (W_REQ_NUM >= 2) && ((W_REQ_NUM & (W_REQ_NUM - 1)) == 0));
`endif

endmodule

// File: tb/tb_write_resp_xbar.sv
// Directed bench for write_resp_xbar: vector table plus hand sequences for stall, reset and counter wrap.
module tb_write_resp_xbar;
    import vector_cache_pkg::*;

    localparam int unsigned W_REQ_NUM = 8;

    logic                                     clk = 1'b0;
    logic                                     rst_n;
    logic [3:0]                               wr_rsp_in_vld;
    logic [3:0]                               wr_rsp_in_rdy;
    wr_resp_pld_t [3:0]                       wr_rsp_in_pld;
    logic [W_REQ_NUM-1:0]                     wr_rsp_vld;
    logic [W_REQ_NUM-1:0]                     wr_rsp_rdy;
    logic [W_REQ_NUM-1:0][TXNID_WIDTH-1:0]    wr_rsp_txnid;
    logic [W_REQ_NUM-1:0][SIDEBAND_WIDTH-1:0] wr_rsp_sideband;
    logic [3:0]                               dealloc_vld;
    logic [3:0][DB_ENTRY_IDX_WIDTH-1:0]       dealloc_idx;
`ifdef WR_RESP_PERF_CNT_EN
    logic [W_REQ_NUM-1:0][31:0]               wr_rsp_cnt;
`endif

    write_resp_xbar #(.W_REQ_NUM(W_REQ_NUM), .FIFO_DEPTH(2)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .wr_rsp_in_vld   (wr_rsp_in_vld),
        .wr_rsp_in_rdy   (wr_rsp_in_rdy),
        .wr_rsp_in_pld   (wr_rsp_in_pld),
        .wr_rsp_vld      (wr_rsp_vld),
        .wr_rsp_rdy      (wr_rsp_rdy),
        .wr_rsp_txnid    (wr_rsp_txnid),
        .wr_rsp_sideband (wr_rsp_sideband),
        .dealloc_vld     (dealloc_vld),
        .dealloc_idx     (dealloc_idx)
`ifdef WR_RESP_PERF_CNT_EN
        ,
        .wr_rsp_cnt      (wr_rsp_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]                          in_vld;
        logic [3:0][TXNID_WIDTH-1:0]         txn;
        logic [3:0][DB_ENTRY_IDX_WIDTH-1:0]  db;
        logic [W_REQ_NUM-1:0]                rdy;
        logic [3:0]                          exp_in_rdy;
        logic [W_REQ_NUM-1:0]                exp_vld;
        logic [W_REQ_NUM-1:0][TXNID_WIDTH-1:0] exp_txn;
        logic [3:0]                          exp_dvld;
        logic [3:0][DB_ENTRY_IDX_WIDTH-1:0]  exp_didx;
    } vec_t;

    vec_t tbl[$];
    vec_t v;
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t blank();
        vec_t b;
        b.in_vld     = '0;
        b.txn        = '0;
        b.db         = '0;
        b.rdy        = '1;
        b.exp_in_rdy = 4'hF;
        b.exp_vld    = '0;
        b.exp_txn    = '0;
        b.exp_dvld   = '0;
        b.exp_didx   = '0;
        return b;
    endfunction

    // Sideband is derived from txnid so the echo path is checked without extra table columns.
    function automatic logic [SIDEBAND_WIDTH-1:0] sb_of(input logic [TXNID_WIDTH-1:0] t);
        return t[SIDEBAND_WIDTH-1:0] ^ 4'hA;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int i, input logic [TXNID_WIDTH-1:0] t,
                            input logic [DB_ENTRY_IDX_WIDTH-1:0] d);
        wr_rsp_in_pld[i].txnid       = t;
        wr_rsp_in_pld[i].sideband    = sb_of(t);
        wr_rsp_in_pld[i].db_entry_id = d;
    endtask

    task automatic apply(input vec_t x);
        for (int i = 0; i < 4; i++) set_lane(i, x.txn[i], x.db[i]);
        wr_rsp_in_vld = x.in_vld;
        wr_rsp_rdy    = x.rdy;
    endtask

    task automatic check_vec(input int k, input vec_t x);
        check($sformatf("v%0d in_rdy", k), 64'(wr_rsp_in_rdy), 64'(x.exp_in_rdy));
        check($sformatf("v%0d rsp_vld", k), 64'(wr_rsp_vld), 64'(x.exp_vld));
        for (int j = 0; j < W_REQ_NUM; j++) begin
            if (x.exp_vld[j]) begin
                check($sformatf("v%0d txnid[%0d]", k, j), 64'(wr_rsp_txnid[j]), 64'(x.exp_txn[j]));
                check($sformatf("v%0d sideband[%0d]", k, j), 64'(wr_rsp_sideband[j]),
                      64'(sb_of(x.exp_txn[j])));
            end
        end
        check($sformatf("v%0d dealloc_vld", k), 64'(dealloc_vld), 64'(x.exp_dvld));
        for (int i = 0; i < 4; i++) begin
            if (x.exp_dvld[i])
                check($sformatf("v%0d dealloc_idx[%0d]", k, i), 64'(dealloc_idx[i]), 64'(x.exp_didx[i]));
        end
    endtask

    initial begin
        // Single response to requester 3, then dealloc one cycle after the handshake.
        v = blank(); v.in_vld = 4'b0001; v.txn[0] = 8'h13; v.db[0] = 6'd5; tbl.push_back(v);
        v = blank(); v.exp_vld = 8'h08; v.exp_txn[3] = 8'h13; tbl.push_back(v);
        v = blank(); v.exp_dvld = 4'b0001; v.exp_didx[0] = 6'd5; tbl.push_back(v);
        v = blank(); tbl.push_back(v);
        // All lanes to requester 2: load under stall, then grants 0,1,2,3,0.
        v = blank(); v.rdy = '0; v.in_vld = 4'hF;
        v.txn[0] = 8'h02; v.txn[1] = 8'h0A; v.txn[2] = 8'h12; v.txn[3] = 8'h1A;
        v.db[0] = 6'd10; v.db[1] = 6'd11; v.db[2] = 6'd12; v.db[3] = 6'd13; tbl.push_back(v);
        v = blank(); v.rdy = '0; v.in_vld = 4'b0001; v.txn[0] = 8'h22; v.db[0] = 6'd14;
        v.exp_vld = 8'h04; v.exp_txn[2] = 8'h02; tbl.push_back(v);
        v = blank(); v.exp_in_rdy = 4'hE; v.exp_vld = 8'h04; v.exp_txn[2] = 8'h02; tbl.push_back(v);
        v = blank(); v.exp_vld = 8'h04; v.exp_txn[2] = 8'h0A;
        v.exp_dvld = 4'b0001; v.exp_didx[0] = 6'd10; tbl.push_back(v);
        v = blank(); v.exp_vld = 8'h04; v.exp_txn[2] = 8'h12;
        v.exp_dvld = 4'b0010; v.exp_didx[1] = 6'd11; tbl.push_back(v);
        v = blank(); v.exp_vld = 8'h04; v.exp_txn[2] = 8'h1A;
        v.exp_dvld = 4'b0100; v.exp_didx[2] = 6'd12; tbl.push_back(v);
        v = blank(); v.exp_vld = 8'h04; v.exp_txn[2] = 8'h22;
        v.exp_dvld = 4'b1000; v.exp_didx[3] = 6'd13; tbl.push_back(v);
        v = blank(); v.exp_dvld = 4'b0001; v.exp_didx[0] = 6'd14; tbl.push_back(v);
        // Four lanes to four distinct requesters pop together.
        v = blank(); v.in_vld = 4'hF;
        v.txn[0] = 8'h30; v.txn[1] = 8'h31; v.txn[2] = 8'h35; v.txn[3] = 8'h37;
        v.db[0] = 6'd20; v.db[1] = 6'd21; v.db[2] = 6'd22; v.db[3] = 6'd23; tbl.push_back(v);
        v = blank(); v.exp_vld = 8'hA3;
        v.exp_txn[0] = 8'h30; v.exp_txn[1] = 8'h31; v.exp_txn[5] = 8'h35; v.exp_txn[7] = 8'h37;
        tbl.push_back(v);
        v = blank(); v.exp_dvld = 4'hF;
        v.exp_didx[0] = 6'd20; v.exp_didx[1] = 6'd21; v.exp_didx[2] = 6'd22; v.exp_didx[3] = 6'd23;
        tbl.push_back(v);
        v = blank(); tbl.push_back(v);

        rst_n         = 1'b0;
        wr_rsp_in_vld = '0;
        wr_rsp_in_pld = '0;
        wr_rsp_rdy    = '0;
        #12;
        check("rst in_rdy", 64'(wr_rsp_in_rdy), 64'(0));
        check("rst rsp_vld", 64'(wr_rsp_vld), 64'(0));
        check("rst dealloc_vld", 64'(dealloc_vld), 64'(0));
        check("rst dealloc_idx", 64'(dealloc_idx), 64'(0));
        tick();
        rst_n = 1'b1;
        #1;
        check("release in_rdy", 64'(wr_rsp_in_rdy), 64'(0));
        tick();
        check("post-release in_rdy", 64'(wr_rsp_in_rdy), 64'hF);

        foreach (tbl[k]) begin
            apply(tbl[k]);
            #1;
            check_vec(k, tbl[k]);
            tick();
        end

        // Requester 1 stalled: lane 1 fills, lane 2 to requester 4 still flows.
        wr_rsp_rdy = 8'hFD;
        set_lane(1, 8'h41, 6'd30);
        set_lane(2, 8'h44, 6'd33);
        wr_rsp_in_vld = 4'b0110;
        tick();
        check("stall in_rdy after 1", 64'(wr_rsp_in_rdy[1]), 64'(1));
        check("stall lane2 vld[4]", 64'(wr_rsp_vld[4]), 64'(1));
        check("stall lane2 txnid", 64'(wr_rsp_txnid[4]), 64'h44);
        set_lane(1, 8'h49, 6'd31);
        wr_rsp_in_vld = 4'b0010;
        tick();
        check("lane2 dealloc_vld", 64'(dealloc_vld[2]), 64'(1));
        check("lane2 dealloc_idx", 64'(dealloc_idx[2]), 64'd33);
        set_lane(1, 8'h51, 6'd32);
        for (int c = 0; c < 3; c++) begin
            check($sformatf("stall%0d in_rdy[1]", c), 64'(wr_rsp_in_rdy[1]), 64'(0));
            check($sformatf("stall%0d vld[1]", c), 64'(wr_rsp_vld[1]), 64'(1));
            check($sformatf("stall%0d txnid[1]", c), 64'(wr_rsp_txnid[1]), 64'h41);
            tick();
        end
        wr_rsp_rdy = '1;
        #1;
        check("unstall in_rdy[1]", 64'(wr_rsp_in_rdy[1]), 64'(0));
        check("unstall txnid 1st", 64'(wr_rsp_txnid[1]), 64'h41);
        tick();
        check("unstall in_rdy back", 64'(wr_rsp_in_rdy[1]), 64'(1));
        check("unstall txnid 2nd", 64'(wr_rsp_txnid[1]), 64'h49);
        check("unstall dealloc 30", 64'(dealloc_idx[1]), 64'd30);
        tick();
        wr_rsp_in_vld = '0;
        check("unstall txnid 3rd", 64'(wr_rsp_txnid[1]), 64'h51);
        check("unstall dealloc 31", 64'(dealloc_idx[1]), 64'd31);
        tick();
        check("unstall dealloc 32", 64'(dealloc_idx[1]), 64'd32);
        check("unstall dealloc_vld", 64'(dealloc_vld), 64'b0010);
        check("unstall drained", 64'(wr_rsp_vld), 64'(0));
        check("unstall in_rdy all", 64'(wr_rsp_in_rdy), 64'hF);

        // Reset with two responses buffered drops them without dealloc.
        wr_rsp_rdy = '0;
        set_lane(0, 8'h60, 6'd40);
        set_lane(3, 8'h66, 6'd41);
        wr_rsp_in_vld = 4'b1001;
        tick();
        wr_rsp_in_vld = '0;
        #1;
        check("pre-reset vld", 64'(wr_rsp_vld), 64'h41);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid-reset vld", 64'(wr_rsp_vld), 64'(0));
        check("mid-reset dealloc_vld", 64'(dealloc_vld), 64'(0));
        check("mid-reset dealloc_idx", 64'(dealloc_idx), 64'(0));
        check("mid-reset in_rdy", 64'(wr_rsp_in_rdy), 64'(0));
        tick();
        tick();
        rst_n = 1'b1;
        wr_rsp_rdy = '1;
        tick();
        check("re-release in_rdy", 64'(wr_rsp_in_rdy), 64'hF);
        check("re-release vld", 64'(wr_rsp_vld), 64'(0));
        tick();
        check("dropped vld", 64'(wr_rsp_vld), 64'(0));
        check("dropped dealloc", 64'(dealloc_vld), 64'(0));

`ifdef WR_RESP_PERF_CNT_EN
        force dut.wr_rsp_cnt = {W_REQ_NUM{32'hFFFF_FFFF}};
        #1;
        release dut.wr_rsp_cnt;
        set_lane(0, 8'h70, 6'd50);
        wr_rsp_in_vld = 4'b0001;
        tick();
        wr_rsp_in_vld = '0;
        check("cnt pre-wrap vld[0]", 64'(wr_rsp_vld[0]), 64'(1));
        tick();
        check("cnt wrap req0", 64'(wr_rsp_cnt[0]), 64'(0));
        check("cnt hold req1", 64'(wr_rsp_cnt[1]), 64'hFFFF_FFFF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
